// File: rtl/data_mem_dump.sv
// rtl/data_mem_dump.sv - post-halt data memory dump: word reads serialised as hi/lo bytes to a UART
//
// Walks word addresses 0..DEPTH-1 on the data memory read port, captures each
// registered read word, and hands it to the transmitter as two bytes (high
// byte first) over a TX_START / TX_DONE handshake. All outputs are decoded
// from state, index and the captured word only.
module data_mem_dump #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 10
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  output logic              MEM_RD,
  output logic              MEM_WR,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [DATA_W-1:0] MEM_DATA,
  output logic [7:0]        TX_DATA,
  output logic              TX_START,
  input  logic              TX_DONE,
  output logic              BUSY,
  output logic              DONE
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_READ    = 4'd1;
  localparam logic [3:0] S_CAPTURE = 4'd2;
  localparam logic [3:0] S_SEND_HI = 4'd3;
  localparam logic [3:0] S_WAIT_HI = 4'd4;
  localparam logic [3:0] S_SEND_LO = 4'd5;
  localparam logic [3:0] S_WAIT_LO = 4'd6;
  localparam logic [3:0] S_NEXT    = 4'd7;
  localparam logic [3:0] S_FINISH  = 4'd8;

  logic [3:0]        state;
  logic [IDX_W-1:0]  index;
  logic [DATA_W-1:0] word;

  // Sequencer: state, word index and captured word; reset aborts any dump in flight.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
      index <= '0;
      word  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            state <= S_READ;
            index <= '0;
          end
        end
        S_READ:    state <= S_CAPTURE;
        S_CAPTURE: begin
          // Memory returns 0 once RD drops, so the word must be latched now.
          word  <= MEM_DATA;
          state <= S_SEND_HI;
        end
        S_SEND_HI: state <= S_WAIT_HI;
        S_WAIT_HI: if (TX_DONE) state <= S_SEND_LO;
        S_SEND_LO: state <= S_WAIT_LO;
        S_WAIT_LO: if (TX_DONE) state <= S_NEXT;
        S_NEXT: begin
          if (index == LAST_IDX) begin
            state <= S_FINISH;
          end else begin
            index <= index + 1'b1;
            state <= S_READ;
          end
        end
        S_FINISH: begin
          index <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore output decode; TX_DATA stays on the current byte through its wait state.
  always_comb begin
    MEM_RD   = 1'b0;
    MEM_WR   = 1'b0;
    MEM_ADDR = ADDR_W'(index);
    TX_DATA  = 8'h00;
    TX_START = 1'b0;
    BUSY     = (state != S_IDLE);
    DONE     = 1'b0;
    case (state)
      S_READ:    MEM_RD = 1'b1;
      S_SEND_HI: begin
        TX_DATA  = word[15:8];
        TX_START = 1'b1;
      end
      S_WAIT_HI: TX_DATA = word[15:8];
      S_SEND_LO: begin
        TX_DATA  = word[7:0];
        TX_START = 1'b1;
      end
      S_WAIT_LO: TX_DATA = word[7:0];
      S_FINISH:  DONE = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_mem_dump.sv
// tb/tb_data_mem_dump.sv - self-checking bench for data_mem_dump (DEPTH=10 and DEPTH=1 builds)
module tb_data_mem_dump;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        mem_rd, mem_wr;
  logic [10:0] mem_addr;
  logic [15:0] mem_data = 16'h0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done = 1'b0;
  logic        busy, done;

  logic        start_b = 1'b0;
  logic        rd_b, wr_b;
  logic [10:0] addr_b;
  logic [15:0] data_b = 16'h0;
  logic [7:0]  txd_b;
  logic        txs_b;
  logic        txdone_b = 1'b1;
  logic        busy_b, done_b;

  data_mem_dump #(.ADDR_W(11), .DATA_W(16), .DEPTH(10)) dut (
    .CLK(clk), .RESET(rst), .START(start),
    .MEM_RD(mem_rd), .MEM_WR(mem_wr), .MEM_ADDR(mem_addr), .MEM_DATA(mem_data),
    .TX_DATA(tx_data), .TX_START(tx_start), .TX_DONE(tx_done),
    .BUSY(busy), .DONE(done)
  );

  data_mem_dump #(.ADDR_W(11), .DATA_W(16), .DEPTH(1)) dut_b (
    .CLK(clk), .RESET(rst), .START(start_b),
    .MEM_RD(rd_b), .MEM_WR(wr_b), .MEM_ADDR(addr_b), .MEM_DATA(data_b),
    .TX_DATA(txd_b), .TX_START(txs_b), .TX_DONE(txdone_b),
    .BUSY(busy_b), .DONE(done_b)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Registered-read memory: data valid the cycle after RD, 0 otherwise.
  logic [15:0] mem [0:15];
  always @(posedge clk) mem_data <= mem_rd ? mem[mem_addr[3:0]] : 16'h0;
  always @(posedge clk) data_b   <= rd_b ? 16'hFFFF : 16'h0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: expected bytes, expected read address, transmitter.
  logic [7:0] exp_q [$];
  logic [7:0] log_q [$];
  int         held_q [$];
  int         rd_idx = 0, busy_cnt = 0, start_cyc = 0, lat = 0, done_cnt = 0;
  int         tx_delay = 1, tx_cnt = 0, held = 0;
  bit         tx_level = 0, pending = 0, prev_rd = 0, prev_done = 0, prev_busy = 0;
  logic [7:0] cur_byte = 8'h0;

  // Compare process and transmitter model for the DEPTH=10 instance.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      pending   = 0;
      tx_cnt    = 0;
      tx_done   = tx_level;
      prev_rd   = 0;
      prev_done = 0;
      prev_busy = 0;
    end else begin
      if (busy && !prev_busy) begin
        exp_q.delete();
        log_q.delete();
        held_q.delete();
        for (int i = 0; i < 10; i++) begin
          exp_q.push_back(mem[i][15:8]);
          exp_q.push_back(mem[i][7:0]);
        end
        rd_idx    = 0;
        busy_cnt  = 0;
        start_cyc = cyc;
      end
      prev_busy = busy;
      if (busy) busy_cnt++;
      chk("mem_wr_low", {31'b0, mem_wr}, 32'd0);
      if (mem_rd) begin
        chk("rd_single_cycle", {31'b0, prev_rd}, 32'd0);
        chk("rd_addr", {21'b0, mem_addr}, rd_idx);
        rd_idx++;
      end
      prev_rd = mem_rd;
      if (tx_start) begin
        chk("tx_start_while_pending", {31'b0, pending}, 32'd0);
        if (exp_q.size() == 0) chk("tx_extra_byte", {24'b0, tx_data}, 32'hFFFF_FFFF);
        else chk("tx_byte", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
        log_q.push_back(tx_data);
        cur_byte = tx_data;
        pending  = 1;
        held     = 0;
        tx_cnt   = tx_delay;
        tx_done  = tx_level;
      end else begin
        if (pending) begin
          chk("tx_hold", {24'b0, tx_data}, {24'b0, cur_byte});
          held++;
        end
        if (tx_level) tx_done = 1'b1;
        else if (tx_cnt > 0) begin
          tx_cnt--;
          tx_done = (tx_cnt == 0);
        end else tx_done = 1'b0;
        if (pending && tx_done) begin
          pending = 0;
          held_q.push_back(held);
        end
      end
      if (done) begin
        chk("done_single_pulse", {31'b0, prev_done}, 32'd0);
        chk("done_all_bytes", exp_q.size(), 32'd0);
        chk("done_reads", rd_idx, 32'd10);
        chk("done_no_pending", {31'b0, pending}, 32'd0);
        lat = cyc - start_cyc;
        done_cnt++;
      end
      prev_done = done;
    end
  end

  logic [7:0] logb_q [$];
  int         done_b_cnt = 0, rd_b_cnt = 0;
  bit         addr_b_nz = 0, wr_b_seen = 0;

  // Observation of the DEPTH=1 instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (txs_b) logb_q.push_back(txd_b);
      if (addr_b != 11'd0) addr_b_nz = 1;
      if (wr_b) wr_b_seen = 1;
      if (rd_b) rd_b_cnt++;
      if (done_b) done_b_cnt++;
    end
  end

  task automatic pulse_start();
    @(negedge clk); #2 start = 1'b1;
    @(negedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int old = done_cnt;
    int n = 0;
    while (done_cnt == old && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    chk("done_seen", {31'b0, done_cnt != old}, 32'd1);
  endtask

  initial begin
    int mx;
    int n;
    int old;
    for (int i = 0; i < 16; i++) mem[i] = 16'h00A5;
    mem[0] = 16'h1234;
    mem[9] = 16'hBEEF;

    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
    chk("rst_addr", {21'b0, mem_addr}, 32'd0);
    chk("rst_tx", {23'b0, tx_start, tx_data}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    // Full dump, immediate ack
    tx_delay = 1; tx_level = 0;
    pulse_start();
    wait_done(500);
    chk("full_count", log_q.size(), 32'd20);
    chk("full_b0", {24'b0, log_q[0]}, 32'h12);
    chk("full_b1", {24'b0, log_q[1]}, 32'h34);
    chk("full_b2", {24'b0, log_q[2]}, 32'h00);
    chk("full_b3", {24'b0, log_q[3]}, 32'hA5);
    chk("full_b18", {24'b0, log_q[18]}, 32'hBE);
    chk("full_b19", {24'b0, log_q[19]}, 32'hEF);
    chk("full_latency", lat, 32'd70);
    chk("full_busy_cycles", busy_cnt, 32'd71);
    chk("mem0_unchanged", {16'b0, mem[0]}, 32'h1234);
    chk("mem9_unchanged", {16'b0, mem[9]}, 32'hBEEF);
    repeat (3) @(negedge clk);

    // Slow transmitter
    mem[0] = 16'h8001;
    tx_delay = 25;
    pulse_start();
    wait_done(2000);
    chk("slow_b0", {24'b0, log_q[0]}, 32'h80);
    chk("slow_b1", {24'b0, log_q[1]}, 32'h01);
    chk("slow_hold_hi", held_q[0], 32'd25);
    chk("slow_hold_last", held_q[19], 32'd25);
    chk("slow_count", log_q.size(), 32'd20);
    repeat (3) @(negedge clk);

    // START abuse with level-high TX_DONE
    tx_level = 1;
    old = done_cnt;
    pulse_start();
    for (int k = 0; k < 12; k++) begin
      repeat (4) @(negedge clk);
      #2 start = 1'b1;
      @(negedge clk); #2 start = 1'b0;
    end
    wait_done(500);
    repeat (20) @(negedge clk);
    #1;
    chk("abuse_one_dump", done_cnt - old, 32'd1);
    chk("abuse_idle_after", {31'b0, busy}, 32'd0);
    chk("abuse_count", log_q.size(), 32'd20);
    mx = 0;
    foreach (held_q[i]) if (held_q[i] > mx) mx = held_q[i];
    chk("abuse_held_max", mx, 32'd1);
    chk("abuse_latency", lat, 32'd70);
    tx_level = 0;
    repeat (3) @(negedge clk);

    // Reset during WAIT_LO of word 3
    tx_delay = 5;
    pulse_start();
    n = 0;
    while (!(log_q.size() == 8 && pending && held >= 1) && n < 1000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("mid_reached_wait_lo", {31'b0, n < 1000}, 32'd1);
    chk("mid_busy_pre", {31'b0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_tx", {23'b0, tx_start, tx_data}, 32'd0);
    chk("mid_rst_mem", {19'b0, mem_rd, mem_addr}, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    @(negedge clk); #2 rst = 1'b0;
    pulse_start();
    wait_done(1000);
    chk("mid_restart_b0", {24'b0, log_q[0]}, 32'h80);
    chk("mid_restart_b1", {24'b0, log_q[1]}, 32'h01);
    chk("mid_restart_count", log_q.size(), 32'd20);

    // DEPTH=1 build
    @(negedge clk); #2 start_b = 1'b1;
    @(negedge clk); #2 start_b = 1'b0;
    n = 0;
    while (done_b_cnt == 0 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("d1_done", done_b_cnt, 32'd1);
    chk("d1_count", logb_q.size(), 32'd2);
    chk("d1_b0", {24'b0, logb_q[0]}, 32'hFF);
    chk("d1_b1", {24'b0, logb_q[1]}, 32'hFF);
    chk("d1_addr_zero", {31'b0, addr_b_nz}, 32'd0);
    chk("d1_no_write", {31'b0, wr_b_seen}, 32'd0);
    chk("d1_reads", rd_b_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
